// File: rtl/operand_loader.sv
// Byte-serial operand loader: assembles four 16-bit operands from an 8-byte frame,
// waits a settle time, captures the single-bit result and hands it off over valid/ack.
module operand_loader #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [15:0] C,
  output logic [15:0] D,
  input  logic        result_in,
  output logic        result_out,
  output logic        result_valid,
  input  logic        result_ack,
  output logic [7:0]  frame_count
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [6:0][7:0] shadow_q, shadow_d;
  logic [15:0]     a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic            res_q, res_d;
  logic            rv_q, rv_d;
  logic [7:0]      fc_q, fc_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    res_d    = res_q;
    rv_d     = rv_q;
    fc_d     = fc_q;

    if (clear) begin
      // Abort: partial shadow bytes become irrelevant once the index restarts.
      state_d = LOAD;
      idx_d   = 3'd0;
      cnt_d   = 4'd0;
      rv_d    = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (byte_valid) begin
            if (idx_q == 3'd7) begin
              // Final byte: publish the whole frame on one edge.
              a_d     = {shadow_q[1], shadow_q[0]};
              b_d     = {shadow_q[3], shadow_q[2]};
              c_d     = {shadow_q[5], shadow_q[4]};
              d_d     = {byte_in, shadow_q[6]};
              idx_d   = 3'd0;
              cnt_d   = SETTLE_INIT;
              state_d = SETTLE;
            end else begin
              for (int i = 0; i < 7; i++) begin
                if (idx_q == 3'(i)) shadow_d[i] = byte_in;
              end
              idx_d = idx_q + 3'd1;
            end
          end
        end
        SETTLE: begin
          if (cnt_q == 4'd0) begin
            res_d   = result_in;
            rv_d    = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (result_ack) begin
            rv_d    = 1'b0;
            fc_d    = fc_q + 8'd1;
            state_d = LOAD;
          end
        end
        default: begin
          state_d = LOAD;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      c_q     <= 16'h0000;
      d_q     <= 16'h0000;
      res_q   <= 1'b0;
      rv_q    <= 1'b0;
      fc_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      fc_q    <= fc_d;
    end
  end

  // Shadow bytes are always overwritten before use, so they carry no reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign byte_ready   = (state_q == LOAD);
  assign A            = a_q;
  assign B            = b_q;
  assign C            = c_q;
  assign D            = d_q;
  assign result_out   = res_q;
  assign result_valid = rv_q;
  assign frame_count  = fc_q;

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: two instances (settle 1 and settle 5) share stimulus,
// a stand-in parity circuit produces result_in, and a monitor checks each captured result.
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        rst, clear, byte_valid, result_ack;
  logic [7:0]  byte_in;
  logic        sel = 1'b0;

  logic        rdy1, res1, rv1, rin1;
  logic [15:0] a1, b1, c1, d1;
  logic [7:0]  fc1;
  logic        rdy5, res5, rv5, rin5;
  logic [15:0] a5, b5, c5, d5;
  logic [7:0]  fc5;

  logic        o_ready, o_res, o_rv;
  logic [15:0] o_a, o_b, o_c, o_d;
  logic [7:0]  o_fc;

  always #5 clk = ~clk;

  assign rin1 = ^{a1, b1, c1, d1};
  assign rin5 = ^{a5, b5, c5, d5};

  operand_loader #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy1), .A(a1), .B(b1), .C(c1), .D(d1), .result_in(rin1),
    .result_out(res1), .result_valid(rv1), .result_ack(result_ack), .frame_count(fc1));

  operand_loader #(.SETTLE_CYCLES(5)) u5 (
    .clk(clk), .rst(rst), .clear(clear), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy5), .A(a5), .B(b5), .C(c5), .D(d5), .result_in(rin5),
    .result_out(res5), .result_valid(rv5), .result_ack(result_ack), .frame_count(fc5));

  assign o_ready = sel ? rdy5 : rdy1;
  assign o_res   = sel ? res5 : res1;
  assign o_rv    = sel ? rv5  : rv1;
  assign o_a     = sel ? a5   : a1;
  assign o_b     = sel ? b5   : b1;
  assign o_c     = sel ? c5   : c1;
  assign o_d     = sel ? d5   : d1;
  assign o_fc    = sel ? fc5  : fc1;

  typedef struct {
    logic [63:0] ops;
    logic        res;
    int          k;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        rv_prev = 1'b0;
  logic [63:0] m_ops = 64'd0;
  logic [7:0]  fc_exp = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising result_valid consumes one scoreboard entry.
  always @(negedge clk) begin
    if (o_rv === 1'b1 && rv_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result_out", {63'd0, o_res}, {63'd0, e.res});
        chk("ops_at_result", {o_d, o_c, o_b, o_a}, e.ops);
        chk("capture_latency", 64'(cyc - e.k), 64'(e.lat));
      end
    end
    rv_prev <= o_rv;
  end

  task automatic check_reset();
    m_ops  = 64'd0;
    fc_exp = 8'd0;
    chk("rst_ops", {o_d, o_c, o_b, o_a}, 64'd0);
    chk("rst_result_out", {63'd0, o_res}, 64'd0);
    chk("rst_result_valid", {63'd0, o_rv}, 64'd0);
    chk("rst_frame_count", {56'd0, o_fc}, 64'd0);
    chk("rst_byte_ready", {63'd0, o_ready}, 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, output int k);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (o_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("byte_stall_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    k = cyc;
  endtask

  task automatic send_frame(input logic [63:0] f, input bit gap, input bit partial, output int k7);
    int k;
    for (int i = 0; i < 8; i++) begin
      if (gap && i > 0) begin
        byte_valid = 1'b0;
        @(posedge clk); #1;
      end
      send_byte(f[8*i +: 8], k);
      if (partial && i < 7) chk("ops_partial", {o_d, o_c, o_b, o_a}, m_ops);
    end
    byte_valid = 1'b0;
    k7    = k;
    m_ops = f;
    chk("ops_after_byte7", {o_d, o_c, o_b, o_a}, m_ops);
    sb.push_back('{ops: f, res: ^f, k: k, lat: (sel ? 5 : 1)});
  endtask

  task automatic wait_valid();
    int n = 0;
    while (o_rv !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_valid", {63'd0, o_rv}, 64'd1);
  endtask

  task automatic hold_ack(input int nhold);
    logic r;
    r = o_res;
    for (int i = 0; i < nhold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, o_rv}, 64'd1);
      chk("hold_result", {63'd0, o_res}, {63'd0, r});
      chk("hold_ready", {63'd0, o_ready}, 64'd0);
    end
    result_ack = 1'b1;
    @(posedge clk); #1;
    result_ack = 1'b0;
    fc_exp++;
    chk("frame_count", {56'd0, o_fc}, {56'd0, fc_exp});
    chk("valid_after_ack", {63'd0, o_rv}, 64'd0);
    chk("ready_after_ack", {63'd0, o_ready}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k0, n;
    rst = 1'b1; clear = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; result_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;

    // Frame 1: bytes 00 00 00 00 01 00 01 00, valid held, immediate ack.
    send_frame(64'h0001_0001_0000_0000, 1'b0, 1'b0, k);
    wait_valid();
    hold_ack(0);

    // Frame 2: outputs must not move until byte7.
    send_frame(64'h0000_FFFF_0000_1234, 1'b0, 1'b1, k);
    chk("frame2_A", {48'd0, o_a}, 64'h1234);
    chk("frame2_C", {48'd0, o_c}, 64'hFFFF);
    wait_valid();
    hold_ack(1);

    // Frames 3/4: gapped valid, frame 4 offered while frame 3 settles/holds.
    send_frame(64'h8877_6655_4433_2211, 1'b1, 1'b1, k);
    fork
      send_frame(64'h0F0E_0D0C_0B0A_0908, 1'b1, 1'b0, k);
      begin
        wait_valid();
        hold_ack(3);
      end
    join
    wait_valid();
    hold_ack(0);

    // Clear after byte4; the byte offered with clear is dropped.
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h11 * 8'(i + 1), k);
      chk("ops_before_clear", {o_d, o_c, o_b, o_a}, m_ops);
    end
    byte_in = 8'hAA;
    clear   = 1'b1;
    @(posedge clk); #1;
    clear      = 1'b0;
    byte_valid = 1'b0;
    chk("clear_ready", {63'd0, o_ready}, 64'd1);
    chk("clear_ops", {o_d, o_c, o_b, o_a}, m_ops);
    send_frame(64'hCAFE_BABE_F00D_BEEF, 1'b0, 1'b1, k);
    wait_valid();
    hold_ack(0);

    // Clear during HOLD: result withdrawn, frame not counted.
    send_frame(64'h1357_9BDF_2468_ACE0, 1'b0, 1'b0, k);
    wait_valid();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_hold_valid", {63'd0, o_rv}, 64'd0);
    chk("clear_hold_ready", {63'd0, o_ready}, 64'd1);
    chk("clear_hold_count", {56'd0, o_fc}, {56'd0, fc_exp});
    chk("clear_hold_result", {63'd0, o_res}, {63'd0, ^m_ops});

    // Ack held high: frames back-to-back at 10 cycles each until the counter wraps.
    n = 256 - int'(fc_exp);
    result_ack = 1'b1;
    for (int j = 0; j < n; j++) begin
      send_frame({32'(j * 32'h9E37_79B9), 32'(~j)}, 1'b0, 1'b0, k);
      if (j == 0) k0 = k;
    end
    chk("frame_period", 64'(k - k0), 64'(10 * (n - 1)));
    repeat (4) @(posedge clk);
    #1;
    result_ack = 1'b0;
    fc_exp = fc_exp + 8'(n);
    chk("fc_wrap", {56'd0, o_fc}, {56'd0, fc_exp});

    // Reset while in HOLD.
    send_frame(64'h0102_0304_0506_0708, 1'b0, 1'b0, k);
    wait_valid();
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset();
    rst = 1'b0;

    // Settle of 5 with ack withheld for 20 cycles.
    rst = 1'b1;
    @(posedge clk); #1;
    sel = 1'b1;
    check_reset();
    rst = 1'b0;
    send_frame(64'hA5A5_0F0F_F0F0_5A5B, 1'b0, 1'b0, k);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("settle5_not_valid", {63'd0, o_rv}, 64'd0);
      chk("settle5_ready", {63'd0, o_ready}, 64'd0);
    end
    wait_valid();
    hold_ack(20);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Byte-serial front end for `combinational_circuit`. It accepts a stream of 8-bit bytes over a valid/ready handshake and assembles four 16-bit operands. It presents the operands atomically on `A`/`B`/`C`/`D`, waits a programmable settle time, then registers the single-bit result coming back from `out_signal`. The captured result is handed to the consumer over a valid/ack handshake, and completed frames are counted.

## Interface
- `SETTLE_CYCLES`, default 1: cycles between operand update and result capture; legal range 1..15.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous abort of the frame in progress.
- `byte_in`  in  8  serial operand data.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `A`, `B`, `C`, `D`  out  16 each  operand registers driving `combinational_circuit`.
- `result_in`  in  1  connected to `out_signal`.
- `result_out`  out  1  registered result.
- `result_valid`  out  1  `result_out` is valid.
- `result_ack`  in  1  consumer accepts the result.
- `frame_count`  out  8  number of acknowledged frames, modulo 256.

## Operation
- A frame is 8 bytes, least-significant byte first, in operand order A, B, C, D:
  - byte0 = `A[7:0]`, byte1 = `A[15:8]`, byte2 = `B[7:0]`, … byte7 = `D[15:8]`.
- A byte is accepted on any edge where `byte_valid && byte_ready`. Bytes 0–6 go to internal shadow registers, and a 3-bit index advances.
- `A`..`D` never show a partial frame.
  - On acceptance of byte7, all four outputs load from the shadow registers plus byte7 on the same edge.
- FSM states:
  - LOAD: `byte_ready`=1. On acceptance of byte7, go to SETTLE, index → 0, settle counter → `SETTLE_CYCLES`-1.
  - SETTLE: `byte_ready`=0. The counter decrements each cycle. When the counter is 0, `result_out` <= `result_in`, `result_valid` <= 1, go to HOLD.
  - HOLD: `byte_ready`=0 and `result_valid`=1. `result_out` is held stable. On an edge with `result_ack`=1: `result_valid` <= 0, `frame_count` <= `frame_count`+1 (wraps 255→0), go to LOAD.
- `result_ack` is ignored outside HOLD.
- `clear` (any state): go to LOAD, index → 0, settle counter → 0, `result_valid` <= 0.
  - Shadow contents are discarded.
  - `A`..`D`, `result_out` and `frame_count` keep their values.
  - A byte presented in the same cycle is dropped (not accepted).
- Priority: `rst` > `clear` > `result_ack`/byte acceptance.

## Timing
- Reset values, one edge after `rst`=1:
  - `A`=`B`=`C`=`D`=0x0000, `result_out`=0, `result_valid`=0, `frame_count`=0.
  - State LOAD, index 0, `byte_ready`=1.
- `byte_ready` is a registered state decode: 1 only in LOAD. It never depends combinationally on `byte_valid`.
- Byte7 accepted at edge k:
  - `A`..`D` are new after edge k.
  - Result captured at edge k+`SETTLE_CYCLES`.
  - `result_valid` high from then until the ack edge.
- Minimum frame period with `SETTLE_CYCLES`=1 and immediate ack: 8 byte cycles + 1 settle + 1 hold = 10 cycles.
- Back-to-back frames: `byte_ready` returns to 1 in the cycle after the ack edge. Bytes presented during SETTLE/HOLD stall; upstream must hold `byte_in`/`byte_valid` until accepted.
- `result_ack` held high across multiple frames acknowledges each frame on its first HOLD cycle.
- `rst` mid-frame or mid-HOLD: the full reset values above apply at the next edge. The in-progress frame is lost and not counted.

## Test plan
- Reset, then 8 bytes 00 00 00 00 01 00 01 00 with `byte_valid` held high, `result_in` driven by a `combinational_circuit` instance, `SETTLE_CYCLES`=1 → `A`=`B`=0x0000, `C`=`D`=0x0001 after byte7. One cycle later `result_out`=1 and `result_valid`=1. Ack → `frame_count`=1.
- Frame 34 12 00 00 FF FF 00 00 → outputs unchanged through byte6. After byte7, `A`=0x1234, `B`=0x0000, `C`=0xFFFF, `D`=0x0000.
- `byte_valid` toggling every other cycle, and bytes offered during SETTLE/HOLD → only handshaked bytes counted, no bytes accepted while `byte_ready`=0, frame content exact.
- `clear` after byte4 of a frame, then a full new frame → `A`..`D` jump straight from the old frame to the new one. The cleared frame is not counted.
- `SETTLE_CYCLES`=5, `result_ack` withheld 20 cycles → result captured exactly 5 edges after byte7. `result_valid` and `result_out` stable for all 20 cycles, `byte_ready`=0 throughout.
- 256 acknowledged frames → `frame_count` wraps to 0. `rst` asserted in HOLD → all outputs reach their reset values at the next edge.
